// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmit scheduler: round-robin accept into a small byte FIFO,
// drained one byte at a time through a send/busy handshake with the UART transmitter.
module uart_tx_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [7:0]               req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [7:0]               req1_data,
  output logic                     req1_ready,
  output logic                     tx_send,
  input  logic                     tx_busy,
  output logic [7:0]               uart_io_thr,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            last_grant1;
  logic            full;
  logic            push;
  logic            pop;
  logic [7:0]      push_data;

  assign full = (fifo_count == CW'(DEPTH));

  // Round-robin grant; last_grant1 set means req0 wins the next tie.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!full) begin
      if (req0_valid && (!req1_valid || last_grant1)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  assign push      = req0_ready | req1_ready;
  assign push_data = req0_ready ? req0_data : req1_data;

  // Send FSM next-state; pop only from IDLE with data and an idle transmitter.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((fifo_count != '0) && !tx_busy) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_send     <= 1'b0;
      uart_io_thr <= 8'h00;
    end else begin
      state_q <= state_d;
      tx_send <= (state_d == SEND);
      if (pop) uart_io_thr <= mem[rd_ptr];
    end
  end

  // FIFO pointers, occupancy and arbitration history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      last_grant1 <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + AW'(1);
        last_grant1 <= req1_ready;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: vector table for arbitration/fill/wrap,
// hand sequences for single-byte latency and mid-transfer reset.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx_send, tx_busy;
  logic [7:0] uart_io_thr;
  logic [2:0] fifo_count;

  logic       auto_busy;
  logic       tb_busy;
  int         bcnt = 0;
  int         send_cnt = 0;
  int         consec = 0;
  logic       prev_send = 1'b0;
  logic [7:0] sent[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_send(tx_send), .tx_busy(tx_busy),
    .uart_io_thr(uart_io_thr), .fifo_count(fifo_count)
  );

  // UART model: busy for 10 cycles after each start pulse.
  always @(posedge clk) begin
    if (tx_send) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = auto_busy ? (bcnt != 0) : tb_busy;

  // Transmit log.
  always @(posedge clk) begin
    if (tx_send) begin
      sent.push_back(uart_io_thr);
      send_cnt <= send_cnt + 1;
      if (prev_send) consec <= consec + 1;
    end
    prev_send <= tx_send;
  end

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       busy;
    logic       r0;
    logic       r1;
    logic       send;
    logic [7:0] thr;
    int         cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base_cnt;
    int base_idx;
    int waited;
    logic [7:0] exp_order [5];

    //              v0  d0     v1  d1     busy r0 r1 send thr    cnt
    tbl[0]  = '{1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[2]  = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2};
    tbl[3]  = '{1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3};
    tbl[4]  = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 3};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 3};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 3};
    tbl[10] = '{1'b1, 8'hA2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA0, 3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB0, 3};
    exp_order[0] = 8'hA0; exp_order[1] = 8'hB0; exp_order[2] = 8'hA1;
    exp_order[3] = 8'hB1; exp_order[4] = 8'hA2;

    rst = 1'b0;
    auto_busy = 1'b1;
    tb_busy = 1'b0;
    idle_inputs();
    #12;
    check("reset.count", int'(fifo_count), 0);
    check("reset.tx_send", int'(tx_send), 0);
    check("reset.thr", int'(uart_io_thr), 0);
    check("reset.readys", int'({req0_ready, req1_ready}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single byte from req0 with modelled 10-cycle busy.
    base_cnt = send_cnt;
    base_idx = sent.size();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h41;
    #1 check("single.r0ready", int'(req0_ready), 1);
    @(negedge clk);
    idle_inputs();
    #1 check("single.count_after_push", int'(fifo_count), 1);
    check("single.no_early_send", int'(tx_send), 0);
    @(negedge clk);
    #1 check("single.tx_send", int'(tx_send), 1);
    check("single.thr", int'(uart_io_thr), 8'h41);
    check("single.count_after_pop", int'(fifo_count), 0);
    repeat (30) @(negedge clk);
    check("single.pulses", send_cnt - base_cnt, 1);
    check("single.logged", (sent.size() > base_idx) ? int'(sent[base_idx]) : -1, 8'h41);
    check("single.count_end", int'(fifo_count), 0);

    // Arbitration, fill to full, wrap with simultaneous push/pop.
    do_reset();
    auto_busy = 1'b0;
    base_cnt = send_cnt;
    base_idx = sent.size();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
      tb_busy = tbl[i].busy;
      #1;
      check($sformatf("vec%0d.r0ready", i), int'(req0_ready), int'(tbl[i].r0));
      check($sformatf("vec%0d.r1ready", i), int'(req1_ready), int'(tbl[i].r1));
      check($sformatf("vec%0d.tx_send", i), int'(tx_send), int'(tbl[i].send));
      check($sformatf("vec%0d.thr", i), int'(uart_io_thr), int'(tbl[i].thr));
      check($sformatf("vec%0d.count", i), int'(fifo_count), tbl[i].cnt);
    end
    @(negedge clk);
    idle_inputs();
    auto_busy = 1'b1;
    waited = 0;
    while ((sent.size() - base_idx) < 5 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("drain.timeout", int'(waited < 1000), 1);
    repeat (30) @(negedge clk);
    check("drain.pulses", send_cnt - base_cnt, 5);
    check("drain.count", int'(fifo_count), 0);
    for (int k = 0; k < 5; k++)
      check($sformatf("drain.order%0d", k),
            (sent.size() > base_idx + k) ? int'(sent[base_idx + k]) : -1, int'(exp_order[k]));

    // Reset while waiting for transmitter with three bytes queued.
    do_reset();
    auto_busy = 1'b0;
    tb_busy = 1'b0;
    @(negedge clk); req0_valid = 1'b1; req0_data = 8'hC0;
    @(negedge clk); req0_data = 8'hC1;
    @(negedge clk); req0_data = 8'hC2; tb_busy = 1'b1;
    @(negedge clk); req0_data = 8'hC3;
    @(negedge clk); idle_inputs();
    #1 check("midrst.count_before", int'(fifo_count), 3);
    check("midrst.thr_before", int'(uart_io_thr), 8'hC0);
    #1 rst = 1'b0;
    #1;
    check("midrst.count", int'(fifo_count), 0);
    check("midrst.tx_send", int'(tx_send), 0);
    check("midrst.thr", int'(uart_io_thr), 0);
    @(negedge clk);
    tb_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    base_cnt = send_cnt;
    #1 check("midrst.first_cycle_send", int'(tx_send), 0);
    repeat (20) @(negedge clk);
    check("midrst.no_send", send_cnt - base_cnt, 0);
    check("midrst.count_after", int'(fifo_count), 0);

    check("no_consecutive_send", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
